// File: rtl/div_share_arbiter.sv
// -----------------------------------------------------------------------------
// div_share_arbiter
//
// Shares a single sequential divider between NREQ requesters. One operation is
// outstanding at a time: a round-robin pick in IDLE latches the winner's
// operands, ISSUE hands them to the divider, BUSY waits for the result, and
// RESP returns it to the same requester before going back to IDLE.
//
// Parameters
//   NREQ   number of requester ports (2..8)
//   WIDTH  operand/result width, must match the divider datapath
//
// Ports
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   req_valid/req_ready            per-requester operation handshake
//   req_dividend/req_divisor       flattened operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready            per-requester result handshake (rsp_valid one-hot)
//   rsp_quotient/rsp_remainder     shared result bus, qualified by rsp_valid
//   div_src_valid/div_src_ready    operand handshake towards the divider
//   div_dividend/div_divisor       latched operands towards the divider
//   div_dst_valid/div_dst_ready    result handshake from the divider
//   div_quotient/div_remainder     divider result
//
// Configuration
//   DIV_ZERO_BYPASS_EN  when defined, a granted operation with divisor 0 skips
//                       the divider and answers quotient all-ones,
//                       remainder = dividend on the next cycle.
// -----------------------------------------------------------------------------
module div_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_quotient,
    output logic [WIDTH-1:0]      rsp_remainder,
    output logic                  div_src_valid,
    input  logic                  div_src_ready,
    output logic [WIDTH-1:0]      div_dividend,
    output logic [WIDTH-1:0]      div_divisor,
    input  logic                  div_dst_valid,
    output logic                  div_dst_ready,
    input  logic [WIDTH-1:0]      div_quotient,
    input  logic [WIDTH-1:0]      div_remainder
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] sel_idx;
    logic             sel_found;
    logic [PTR_W:0]   cand;
    logic [PTR_W:0]   ptr_inc;
    logic [WIDTH-1:0] sel_dividend, sel_divisor;
    logic [WIDTH-1:0] dividend_q, divisor_q, quotient_q, remainder_q;

    // Round-robin pick: first requester at or after rr_ptr, wrapping mod NREQ.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NREQ))
                cand = cand - (PTR_W+1)'(NREQ);
            if (!sel_found && req_valid[cand[PTR_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign sel_dividend = req_dividend[int'(sel_idx)*WIDTH +: WIDTH];
    assign sel_divisor  = req_divisor[int'(sel_idx)*WIDTH +: WIDTH];

    // Pointer moves to the port after the winner so it has lowest priority next time.
    assign ptr_inc    = {1'b0, sel_idx} + (PTR_W+1)'(1);
    assign rr_ptr_nxt = (ptr_inc == (PTR_W+1)'(NREQ)) ? '0 : ptr_inc[PTR_W-1:0];

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: operand/result registers are reset too, so the divider and result buses show 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_idx   <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_idx  <= sel_idx;
                        dividend_q <= sel_dividend;
                        divisor_q  <= sel_divisor;
                        rr_ptr     <= rr_ptr_nxt;
`ifdef DIV_ZERO_BYPASS_EN
                        if (sel_divisor == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= sel_dividend;
                        end
`endif
                    end
                end
                BUSY: begin
                    if (div_dst_valid) begin
                        quotient_q  <= div_quotient;
                        remainder_q <= div_remainder;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sel_found) begin
`ifdef DIV_ZERO_BYPASS_EN
                    state_nxt = (sel_divisor == '0) ? RESP : ISSUE;
`else
                    state_nxt = ISSUE;
`endif
                end
            end
            ISSUE:   if (div_src_ready)          state_nxt = BUSY;
            BUSY:    if (div_dst_valid)          state_nxt = RESP;
            RESP:    if (rsp_ready[grant_idx])   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode. req_ready is held low while reset is asserted so no
    // requester sees an accept that the register update would discard.
    always_comb begin
        req_ready     = '0;
        rsp_valid     = '0;
        div_src_valid = 1'b0;
        div_dst_ready = 1'b0;
        case (state)
            IDLE:    if (sel_found && !reset) req_ready[sel_idx] = 1'b1;
            ISSUE:   div_src_valid = 1'b1;
            BUSY:    div_dst_ready = 1'b1;
            RESP:    rsp_valid[grant_idx] = 1'b1;
            default: ;
        endcase
    end

    assign div_dividend  = dividend_q;
    assign div_divisor   = divisor_q;
    assign rsp_quotient  = quotient_q;
    assign rsp_remainder = remainder_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_div_share_arbiter
//
// Directed bench for div_share_arbiter (NREQ=4, WIDTH=32). The bench plays the
// divider itself: it answers each issued operation with hand-computed
// quotient/remainder values and checks the arbiter's grant order, operand
// hand-off, result return, backpressure behaviour, reset and divide-by-zero.
// -----------------------------------------------------------------------------
module tb_div_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_dividend;
    logic [NREQ*WIDTH-1:0] req_divisor;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]      rsp_quotient;
    logic [WIDTH-1:0]      rsp_remainder;
    logic                  div_src_valid;
    logic                  div_src_ready;
    logic [WIDTH-1:0]      div_dividend;
    logic [WIDTH-1:0]      div_divisor;
    logic                  div_dst_valid;
    logic                  div_dst_ready;
    logic [WIDTH-1:0]      div_quotient;
    logic [WIDTH-1:0]      div_remainder;

    int checks = 0;
    int errors = 0;

    div_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .div_src_valid (div_src_valid),
        .div_src_ready (div_src_ready),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_dst_valid (div_dst_valid),
        .div_dst_ready (div_dst_ready),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One full operation on a port whose req_valid the caller has already raised.
    // Called while the arbiter is in IDLE, just after a rising edge.
    task automatic run_op(input int port, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input int src_stall, input int rsp_stall);
        logic [NREQ-1:0] onehot;
        onehot = NREQ'(1 << port);
        req_dividend[port*WIDTH +: WIDTH] = a;
        req_divisor[port*WIDTH +: WIDTH]  = b;

        @(negedge clk);
        check("grant", 32'(req_ready), 32'(onehot));
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();

        @(negedge clk);
        check("src_valid", 32'(div_src_valid), 32'd1);
        check("div_dividend", div_dividend, a);
        check("div_divisor", div_divisor, b);
        for (int i = 0; i < src_stall; i++) begin
            tick();
            @(negedge clk);
            check("src_hold_valid", 32'(div_src_valid), 32'd1);
            check("src_hold_dividend", div_dividend, a);
            check("src_hold_divisor", div_divisor, b);
            check("src_hold_no_grant", 32'(req_ready), 32'd0);
        end
        div_src_ready = 1'b1;
        tick();
        div_src_ready = 1'b0;

        @(negedge clk);
        check("dst_ready", 32'(div_dst_ready), 32'd1);
        check("src_valid_dropped", 32'(div_src_valid), 32'd0);
        div_dst_valid = 1'b1;
        div_quotient  = exp_q;
        div_remainder = exp_r;
        tick();
        div_dst_valid = 1'b0;
        div_quotient  = 32'hDEAD_BEEF;
        div_remainder = 32'hDEAD_BEEF;

        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 32'(onehot));
        check("rsp_quotient", rsp_quotient, exp_q);
        check("rsp_remainder", rsp_remainder, exp_r);
        for (int i = 0; i < rsp_stall; i++) begin
            rsp_ready = ~onehot;  // other ports' ready must be ignored
            tick();
            @(negedge clk);
            check("rsp_hold_valid", 32'(rsp_valid), 32'(onehot));
            check("rsp_hold_quotient", rsp_quotient, exp_q);
            check("rsp_hold_remainder", rsp_remainder, exp_r);
            check("rsp_hold_no_grant", 32'(req_ready), 32'd0);
        end
        rsp_ready = onehot;
        tick();
        rsp_ready = '0;
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = '1;
        req_dividend  = '0;
        req_divisor   = '0;
        rsp_ready     = '0;
        div_src_ready = 1'b0;
        div_dst_valid = 1'b0;
        div_quotient  = '0;
        div_remainder = '0;

        // Reset state, with requests already pending.
        tick();
        tick();
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_src_valid", 32'(div_src_valid), 32'd0);
        check("rst_dst_ready", 32'(div_dst_ready), 32'd0);
        check("rst_div_dividend", div_dividend, 32'd0);
        check("rst_rsp_quotient", rsp_quotient, 32'd0);
        req_valid = '0;
        tick();
        reset = 1'b0;
        tick();

        // Idle with no requests: nothing is granted or issued.
        @(negedge clk);
        check("idle_no_grant", 32'(req_ready), 32'd0);
        tick();
        @(negedge clk);
        check("idle_no_issue", 32'(div_src_valid), 32'd0);
        tick();

        // Single operation on port 0: 100 / 7 = 14 r 2.
        req_valid = 4'b0001;
        run_op(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0);
        req_valid = '0;

        // All four requesting continuously from reset: grant order 0,1,2,3,0.
        do_reset();
        req_valid = 4'b1111;
        run_op(0, 32'd20,   32'd3,  32'd6,   32'd2,  0, 0);
        run_op(1, 32'd45,   32'd6,  32'd7,   32'd3,  0, 0);
        run_op(2, 32'd1000, 32'd10, 32'd100, 32'd0,  0, 0);
        run_op(3, 32'd7,    32'd9,  32'd0,   32'd7,  0, 0);
        run_op(0, 32'd255,  32'd16, 32'd15,  32'd15, 0, 0);

        // Backpressure on both sides while port 2 keeps requesting (rr_ptr=1 -> port 1).
        req_valid = 4'b0110;
        run_op(1, 32'd81, 32'd4, 32'd20, 32'd1, 5, 4);

        // rr_ptr=2 with requests on 0 and 1: wraps to port 0, then rr_ptr=1 picks port 1.
        req_valid = 4'b0011;
        run_op(0, 32'd12, 32'd5, 32'd2, 32'd2, 0, 0);
        run_op(1, 32'd13, 32'd4, 32'd3, 32'd1, 0, 0);
        req_valid = '0;

        // Reset while BUSY discards the operation; a fresh one then completes.
        req_valid = 4'b0100;
        req_dividend[2*WIDTH +: WIDTH] = 32'd77;
        req_divisor[2*WIDTH +: WIDTH]  = 32'd3;
        @(negedge clk);
        check("busy_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid     = '0;
        div_src_ready = 1'b1;
        tick();
        div_src_ready = 1'b0;
        @(negedge clk);
        check("busy_reached", 32'(div_dst_ready), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_dst_ready", 32'(div_dst_ready), 32'd0);
        check("midrst_src_valid", 32'(div_src_valid), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_div_dividend", div_dividend, 32'd0);
        check("midrst_rsp_quotient", rsp_quotient, 32'd0);
        tick();
        req_valid = 4'b0001;
        run_op(0, 32'd50, 32'd5, 32'd10, 32'd0, 0, 0);
        req_valid = '0;

        // Divide by zero on port 3, dividend 9.
        req_valid = 4'b1000;
`ifdef DIV_ZERO_BYPASS_EN
        req_dividend[3*WIDTH +: WIDTH] = 32'd9;
        req_divisor[3*WIDTH +: WIDTH]  = 32'd0;
        @(negedge clk);
        check("dz_grant", 32'(req_ready), 32'b1000);
        tick();
        @(negedge clk);
        check("dz_src_valid", 32'(div_src_valid), 32'd0);
        check("dz_rsp_valid", 32'(rsp_valid), 32'b1000);
        check("dz_quotient", rsp_quotient, 32'hFFFF_FFFF);
        check("dz_remainder", rsp_remainder, 32'd9);
        rsp_ready = 4'b1000;
        tick();
        rsp_ready = '0;
        @(negedge clk);
        check("dz_done_src_valid", 32'(div_src_valid), 32'd0);
        check("dz_done_rsp_valid", 32'(rsp_valid), 32'd0);
`else
        // Without the bypass the operation goes to the divider; this divider answers all-ones / dividend.
        run_op(3, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 0, 0);
`endif
        req_valid = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
